// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock
// through a registered borrow, with valid/ready handshakes on both sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready=1
  // RUN   | one result bit per cycle, WIDTH cycles
  // DONE  | result held on outputs until out_ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, part, part_nxt;
  logic [CW-1:0]    cnt;
  logic             br, d, br_nxt, last;

  assign d        = sh_a[0] ^ sh_b[0] ^ br;
  assign br_nxt   = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);
  assign part_nxt = {d, part[WIDTH-1:1]};
  assign last     = (cnt == CW'(WIDTH - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a   <= '0;
      sh_b   <= '0;
      part   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a <= a;
            sh_b <= b;
            part <= '0;
            cnt  <= '0;
            br   <= 1'b0;
          end
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          part <= part_nxt;
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          // Result registers only move on the final bit, so they hold through IDLE/RUN.
          if (last) begin
            diff   <= part_nxt;
            borrow <= br_nxt;
            zero   <= (part_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): directed vector table with latency checks,
// backpressure, async reset mid-run, and a random sweep checked by a scoreboard.
module tb_serial_subtractor;

  logic       clk, rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, diff;
  logic       borrow, zero;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .zero(zero)
  );

  typedef struct {
    logic [7:0] a, b, d;
    logic       br, z;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       br, z;
  } exp_t;

  int   total = 0, bad = 0;
  int   n_acc = 0, n_res = 0;
  exp_t q[$];
  logic rand_ready = 1'b0;
  vec_t vecs[5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push model result on accept, pop and compare on result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      n_acc -= q.size();
      q.delete();
    end else begin
      if (in_valid && in_ready) begin
        e.d  = a - b;
        e.br = (a < b);
        e.z  = ((a - b) & 8'hFF) == 0;
        q.push_back(e);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_diff", diff, e.d);
          chk("sb_borrow", borrow, e.br);
          chk("sb_zero", zero, e.z);
          n_res++;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Directed op with out_ready=1, checking exact latency and single-cycle out_valid.
  task automatic run_op(input vec_t v);
    @(posedge clk); #1;
    a = v.a; b = v.b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~v.a; b = ~v.b;
    chk("in_ready_run", in_ready, 1'b0);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      chk("out_valid_early", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    chk("out_valid_lat", out_valid, 1'b1);
    chk("diff", diff, v.d);
    chk("borrow", borrow, v.br);
    chk("zero", zero, v.z);
    @(posedge clk); #1;
    chk("out_valid_drop", out_valid, 1'b0);
    chk("in_ready_back", in_ready, 1'b1);
    chk("diff_retained", diff, v.d);
  endtask

  initial begin
    vecs[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, br: 1'b0, z: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, br: 1'b1, z: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'hFF, d: 8'h01, br: 1'b1, z: 1'b0};
    vecs[3] = '{a: 8'h7F, b: 8'h7F, d: 8'h00, br: 1'b0, z: 1'b1};
    vecs[4] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, br: 1'b0, z: 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_borrow", borrow, 1'b0);
    chk("rst_zero", zero, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Backpressure, with ignored in_valid pulses during RUN and DONE.
    begin
      bit seen = 0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      a = 8'hA0; b = 8'h0A; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 8'h11; b = 8'h22;
      for (int t = 0; t < 20; t++) begin
        in_valid = t[0];
        if (out_valid) begin seen = 1; break; end
        @(posedge clk); #1;
      end
      chk("bp_out_valid_rise", seen, 1'b1);
      for (int t = 0; t < 5; t++) begin
        in_valid = ~t[0];
        @(posedge clk); #1;
        chk("bp_out_valid_hold", out_valid, 1'b1);
        chk("bp_diff", diff, 8'h96);
        chk("bp_borrow", borrow, 1'b0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", out_valid, 1'b0);
      chk("bp_in_ready", in_ready, 1'b1);
    end

    // Async reset mid-run.
    @(posedge clk); #1;
    a = 8'h55; b = 8'h22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_diff", diff, 8'h00);
    chk("mid_rst_borrow", borrow, 1'b0);
    chk("mid_rst_zero", zero, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      chk("no_stale_out_valid", out_valid, 1'b0);
    end
    run_op('{a: 8'h10, b: 8'h01, d: 8'h0F, br: 1'b0, z: 1'b0});

    // Random sweep with input gaps and random out_ready.
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      bit acc = 0, ok;
      @(posedge clk); #1;
      a = 8'($urandom); b = 8'($urandom);
      if (n % 50 == 0) b = a;
      in_valid = 1'b1;
      for (int t = 0; t < 60; t++) begin
        ok = in_ready;
        @(posedge clk); #1;
        if (ok) begin acc = 1; break; end
      end
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom);
      if (!acc) chk("rand_accept_timeout", 32'd0, 32'd1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    begin
      int t = 0;
      while (q.size() != 0 && t < 100) begin @(posedge clk); t++; end
    end
    rand_ready = 1'b0;
    #2 out_ready = 1'b1;
    chk("sb_drained", q.size(), 0);
    chk("results_vs_accepts", n_res, n_acc);
    chk("accept_count", (n_acc >= 1000), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
